// File: rtl/addsub_serial_pkg.sv
// Shared state encoding and operation-mode constants for the serial adder/subtractor.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its MSB.
module addsub_serial_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    assign sum[gi]     = x[gi] ^ y[gi] ^ carry[gi];
    assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
  end

  assign cout = carry[DIGIT];
  assign cmsb = carry[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor: a + (sub ? ~b : b) + ci, DIGIT bits per clock, LSB first,
// with start/done handshake and registered carry-out and signed-overflow flags.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_param_err
    $error("addsub_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout, dig_cmsb;
  logic [WIDTH-1:0] res_shift;

  addsub_serial_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (c_q),
    .sum  (dig_sum),
    .cout (dig_cout),
    .cmsb (dig_cmsb)
  );

  // New digit enters at the top so that after N steps the LSB digit sits at bit 0.
  assign res_shift = WIDTH'({dig_sum, res_q} >> DIGIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = (sub == ADDSUB_ADD) ? b : ~b;
          c_d     = ci;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dig_cout;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          s_d     = res_shift;
          co_d    = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
